ex_pipe_stage: RTL and testbench
================================

EX_PIPE_STAGE -- requirements
Module: ex_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (allowed 32 or 64).
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount bits (SHAMT_W = log2(XLEN)).
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk_cpu  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- in_valid  in  1  issue slot valid.
- in_ready  out  1  stage can accept.
- op  in  4  ALU opcode (package enum).
- alusrc  in  1  1: operand B = imm, 0: operand B = b.
- a, b, imm, pc  in  XLEN  operands, immediate, instruction PC.
- ir  in  32  instruction word.
- br_en  in  1  conditional branch.
- jal  in  1  unconditional jump.
- flush  in  1  kill in-flight op.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- y  out  XLEN  result.
- mdw  out  XLEN  store data (registered b).
- irm  out  32  registered ir.
- br_taken  out  1  redirect.
- br_target  out  XLEN  pc+imm.
- illegal_op  out  1  unsupported opcode.

Function
REQ-004 SHALL accept an op in a cycle where in_valid & in_ready; in_ready = ~busy & (~out_valid | out_ready).
REQ-005 SHALL register y, mdw, irm, br_taken, br_target and illegal_op, and set out_valid, on the edge after accept for single-cycle ops (latency 1).
REQ-006 SHALL support ADD, SUB, SLL, SRL, SRA, AND, OR, XOR, SLT, SLTU, AUIPC (pc+imm) and LUI (imm); MUL, DIVU and REMU are additionally supported per REQ-017.
REQ-007 SHALL use operand B[SHAMT_W-1:0] for shifts; all arithmetic SHALL be modulo 2^XLEN.
REQ-008 SHALL set br_taken = jal | (br_en & cond), with cond from ir[14:12]: 000 a==b, 001 a!=b, 100 signed <, 101 signed >=, 110 unsigned <, 111 unsigned >=; funct3 010/011 give cond=0.
REQ-009 SHALL drive br_target = pc+imm, wrapping modulo 2^XLEN.
REQ-010 SHALL hold all outputs stable while out_valid & ~out_ready.
REQ-011 SHALL clear out_valid after a handshake (out_valid & out_ready) unless a new op is accepted in the same cycle.
REQ-012 SHALL make flush a synchronous kill: next cycle out_valid=0, busy=0, any iterative op aborted; flush SHALL override a simultaneous accept (op dropped).
REQ-013 SHALL assert illegal_op with out_valid for an undefined opcode, with y=0 and br_taken=0.

Reset
REQ-014 SHALL, while rstn=0, force out_valid=0, busy=0, y=mdw=br_target=0, irm=0, br_taken=0, illegal_op=0 and the iteration counter=0.
REQ-015 SHALL, on rstn low during an iterative op, abandon the op with no result produced; in_ready=1 on the first cycle after release.
REQ-016 SHALL keep reset asynchronous on assertion; release is assumed synchronous to clk_cpu upstream.

Configuration
REQ-017 SHALL, with macro EX_MULDIV_EN defined, implement MUL (low XLEN bits), DIVU and REMU iteratively: busy for XLEN cycles after accept, out_valid on the edge XLEN+1 cycles after accept, in_ready=0 while busy.
REQ-018 SHALL, with EX_MULDIV_EN defined, return quotient=all-ones and remainder=a for divide-by-zero, at the same latency.
REQ-019 SHALL, without EX_MULDIV_EN, treat MUL/DIVU/REMU as illegal (REQ-013, latency 1), with no iterative logic synthesised.

Structure
REQ-020 SHALL place the op enum (4-bit), the funct3 branch codes and the ALU/JAL opcode constants in package ex_pkg.
REQ-021 SHALL place the shift-add multiplier / restoring divider in sub-module ex_muldiv_iter (start, done, XLEN parameter), instantiated only under EX_MULDIV_EN.

Verification
REQ-022 SHALL check ADD: a=0xFFFFFFFF, b=1, alusrc=0 -> y=0x00000000, out_valid one cycle after accept.
REQ-023 SHALL check BLT: ir[14:12]=100, br_en=1, a=0xFFFFFFFE, b=1 -> br_taken=1; same operands with funct3=110 -> br_taken=0.
REQ-024 SHALL check backpressure: out_ready=0 for 3 cycles after result -> y stable, in_ready=0; out_ready=1 -> handshake, in_ready=1.
REQ-025 SHALL check DIVU (macro on, XLEN=32): a=100, b=7 -> y=14 at 33 cycles after accept; b=0 -> y=0xFFFFFFFF.
REQ-026 SHALL check flush mid-DIVU (cycle 10) -> no out_valid, in_ready=1 next cycle; flush with simultaneous accept -> op dropped.
REQ-027 SHALL check rstn pulsed low mid-MUL -> all outputs 0 immediately; macro off, op=MUL -> illegal_op=1, y=0 at latency 1.

Source files
------------

// File: rtl/ex_pipe_stage_pkg.sv
// Shared types for the execute stage: ALU opcode enum, branch funct3 codes
// and opcode classification helpers.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SRL   = 4'd3,
    OP_SRA   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_AUIPC = 4'd10,
    OP_LUI   = 4'd11,
    OP_MUL   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REMU  = 4'd14
  } op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // md_en says whether the iterative unit exists in this build.
  function automatic logic op_known(input logic [3:0] op, input logic md_en);
    return (op <= OP_LUI) || (md_en && is_muldiv(op));
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unit: shift-add multiplier (low XLEN bits) and restoring divider,
// one bit per cycle; done is raised after exactly XLEN steps.
module ex_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_cpu,
  input  logic            rstn,
  input  logic            start,
  input  logic            kill,
  input  logic            div,
  input  logic            rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  logic            running, is_div, is_rem;
  logic [CW-1:0]   cnt;
  // hi: product accumulator / partial remainder; lo: multiplier / dividend->quotient
  logic [XLEN-1:0] hi, lo, opd;
  logic [XLEN:0]   rem_sh, diff;

  assign rem_sh = {hi, lo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, opd};
  assign done   = running & (cnt == LAST);
  assign result = (is_div & ~is_rem) ? lo : hi;

  // A zero divisor never borrows, so quotient fills with ones and the
  // remainder shifts in the whole dividend without special casing.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      running <= 1'b0;
      is_div  <= 1'b0;
      is_rem  <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opd     <= '0;
    end else if (kill) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      is_div  <= div;
      is_rem  <= rem;
      hi      <= '0;
      lo      <= div ? a : b;
      opd     <= div ? b : a;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          if (!diff[XLEN]) begin
            hi <= diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= rem_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
        end else begin
          if (lo[0]) hi <= hi + opd;
          opd <= opd << 1;
          lo  <= lo >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/ex_pipe_stage.sv
// Single-slot execute stage with valid/ready handshake, branch resolution and
// optional iterative MUL/DIVU/REMU (enabled by macro EX_MULDIV_EN).
module ex_pipe_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_cpu,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            alusrc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     ir,
  input  logic            br_en,
  input  logic            jal,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic [XLEN-1:0] mdw,
  output logic [31:0]     irm,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal_op
);

  logic               busy, accept, md_op, md_done, illegal_c, cond, br_taken_c;
  logic [XLEN-1:0]    opb, alu_y, md_res;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = ~busy & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;

`ifdef EX_MULDIV_EN
  assign md_op     = is_muldiv(op);
  assign illegal_c = ~op_known(op, 1'b1);

  ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk_cpu (clk_cpu),
    .rstn    (rstn),
    .start   (accept & md_op),
    .kill    (flush),
    .div     (op != OP_MUL),
    .rem     (op == OP_REMU),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .result  (md_res)
  );
`else
  assign md_op     = 1'b0;
  assign md_done   = 1'b0;
  assign md_res    = '0;
  assign illegal_c = ~op_known(op, 1'b0);
`endif

  assign opb   = alusrc ? imm : b;
  assign shamt = opb[SHAMT_W-1:0];

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:   alu_y = a + opb;
      OP_SUB:   alu_y = a - opb;
      OP_SLL:   alu_y = a << shamt;
      OP_SRL:   alu_y = a >> shamt;
      OP_SRA:   alu_y = $unsigned($signed(a) >>> shamt);
      OP_AND:   alu_y = a & opb;
      OP_OR:    alu_y = a | opb;
      OP_XOR:   alu_y = a ^ opb;
      OP_SLT:   alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(opb)};
      OP_SLTU:  alu_y = {{(XLEN-1){1'b0}}, a < opb};
      OP_AUIPC: alu_y = pc + imm;
      OP_LUI:   alu_y = imm;
      default:  alu_y = '0;
    endcase
  end

  // Branch compare always uses the register operand b, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (ir[14:12])
      F3_BEQ:  cond = (a == b);
      F3_BNE:  cond = (a != b);
      F3_BLT:  cond = ($signed(a) < $signed(b));
      F3_BGE:  cond = ($signed(a) >= $signed(b));
      F3_BLTU: cond = (a < b);
      F3_BGEU: cond = (a >= b);
      default: cond = 1'b0;
    endcase
  end

  assign br_taken_c = ~illegal_c & (jal | (br_en & cond));

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      y          <= '0;
      mdw        <= '0;
      irm        <= '0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      mdw        <= b;
      irm        <= ir;
      br_target  <= pc + imm;
      br_taken   <= br_taken_c;
      illegal_op <= illegal_c;
      if (!md_op) y <= alu_y;
      out_valid  <= ~md_op;
      busy       <= md_op;
    end else if (md_done) begin
      y         <= md_res;
      out_valid <= 1'b1;
      busy      <= 1'b0;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_pipe_stage.sv
// Directed bench for ex_pipe_stage: vector table for single-cycle ops plus
// hand sequences for backpressure, flush, reset and iterative ops.
module tb_ex_pipe_stage;
  import ex_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        rstn, in_valid, in_ready, alusrc, br_en, jal, flush;
  logic        out_valid, out_ready, br_taken, illegal_op;
  logic [3:0]  op;
  logic [31:0] a, b, imm, pc, ir, y, mdw, irm, br_target;

  int total = 0;
  int bad   = 0;

  ex_pipe_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_cpu(clk_cpu), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alusrc(alusrc), .a(a), .b(b), .imm(imm), .pc(pc), .ir(ir),
    .br_en(br_en), .jal(jal), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .mdw(mdw), .irm(irm), .br_taken(br_taken),
    .br_target(br_target), .illegal_op(illegal_op)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        alusrc;
    logic [31:0] a, b, imm, pc, ir;
    logic        br_en, jal;
    logic [31:0] ey;
    logic        ebt, eill;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string n, logic [3:0] o, logic s, logic [31:0] va, vb,
                              vimm, vpc, vir, logic be, logic j, logic [31:0] ey,
                              logic ebt, logic eill);
    vec_t v;
    v.name = n; v.op = o; v.alusrc = s; v.a = va; v.b = vb; v.imm = vimm;
    v.pc = vpc; v.ir = vir; v.br_en = be; v.jal = j; v.ey = ey; v.ebt = ebt; v.eill = eill;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic drive(logic [3:0] o, logic s, logic [31:0] va, vb, vimm, vpc, vir,
                       logic be, logic j);
    op = o; alusrc = s; a = va; b = vb; imm = vimm; pc = vpc; ir = vir; br_en = be; jal = j;
  endtask

  // Issue one iterative op and check its XLEN+1 latency and result.
  task automatic md_run(string n, logic [3:0] o, logic [31:0] va, vb, logic [31:0] ey);
    logic seen;
    seen = 1'b0;
    drive(o, 1'b0, va, vb, 32'h0, 32'h0, 32'h0200_0033, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      seen |= out_valid;
      if (i == 16) chk({n, " in_ready busy"}, {31'b0, in_ready}, 32'd0);
      step();
    end
    seen |= out_valid;
    chk({n, " no early valid"}, {31'b0, seen}, 32'd0);
    step();
    chk({n, " valid at 33"}, {31'b0, out_valid}, 32'd1);
    chk({n, " y"}, y, ey);
    step();
  endtask

  initial begin
    logic seen;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    tv.push_back(mk("add wrap", OP_ADD,  0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h33, 0, 0, 32'h0, 0, 0));
    tv.push_back(mk("sub neg",  OP_SUB,  0, 32'h5, 32'h7, 32'h0, 32'h0, 32'h33, 0, 0, 32'hFFFF_FFFE, 0, 0));
    tv.push_back(mk("sll imm",  OP_SLL,  1, 32'h1, 32'h55, 32'h3F, 32'h0, 32'h13, 0, 0, 32'h8000_0000, 0, 0));
    tv.push_back(mk("srl",      OP_SRL,  0, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h33, 0, 0, 32'h0800_0000, 0, 0));
    tv.push_back(mk("sra",      OP_SRA,  0, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h33, 0, 0, 32'hF800_0000, 0, 0));
    tv.push_back(mk("and",      OP_AND,  0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h33, 0, 0, 32'h00F0_00F0, 0, 0));
    tv.push_back(mk("or",       OP_OR,   0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h33, 0, 0, 32'hFFF0_FFF0, 0, 0));
    tv.push_back(mk("xor",      OP_XOR,  0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h33, 0, 0, 32'hFF00_FF00, 0, 0));
    tv.push_back(mk("slt",      OP_SLT,  0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0, 32'h33, 0, 0, 32'h1, 0, 0));
    tv.push_back(mk("sltu",     OP_SLTU, 0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0, 32'h33, 0, 0, 32'h0, 0, 0));
    tv.push_back(mk("auipc",    OP_AUIPC,0, 32'h0, 32'h0, 32'h20, 32'hFFFF_FFF0, 32'h17, 0, 0, 32'h10, 0, 0));
    tv.push_back(mk("lui",      OP_LUI,  1, 32'h0, 32'h9, 32'h1234_5000, 32'h0, 32'h37, 0, 0, 32'h1234_5000, 0, 0));
    tv.push_back(mk("blt",      OP_ADD,  0, 32'hFFFF_FFFE, 32'h1, 32'h10, 32'h100, 32'h0000_4063, 1, 0, 32'hFFFF_FFFF, 1, 0));
    tv.push_back(mk("bltu",     OP_ADD,  0, 32'hFFFF_FFFE, 32'h1, 32'h10, 32'h100, 32'h0000_6063, 1, 0, 32'hFFFF_FFFF, 0, 0));
    tv.push_back(mk("beq",      OP_ADD,  0, 32'h5, 32'h5, 32'h40, 32'h200, 32'h0000_0063, 1, 0, 32'hA, 1, 0));
    tv.push_back(mk("f3 010",   OP_ADD,  0, 32'h5, 32'h5, 32'h40, 32'h200, 32'h0000_2063, 1, 0, 32'hA, 0, 0));
    tv.push_back(mk("bgeu",     OP_ADD,  0, 32'h1, 32'hFFFF_FFFF, 32'h4, 32'h0, 32'h0000_7063, 1, 0, 32'h0, 0, 0));
    tv.push_back(mk("jal wrap", OP_ADD,  0, 32'h1, 32'h2, 32'h8, 32'hFFFF_FFFC, 32'h6F, 0, 1, 32'h3, 1, 0));
    tv.push_back(mk("illegal",  4'd15,   0, 32'h3, 32'h4, 32'h8, 32'h0, 32'h6F, 1, 1, 32'h0, 0, 1));
`ifndef EX_MULDIV_EN
    tv.push_back(mk("mul off",  OP_MUL,  0, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0200_0033, 0, 0, 32'h0, 0, 1));
    tv.push_back(mk("divu off", OP_DIVU, 0, 32'h64, 32'h7, 32'h0, 32'h0, 32'h0200_5033, 0, 0, 32'h0, 0, 1));
`endif

    step(); step();
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst y", y, 32'd0);
    chk("rst mdw", mdw, 32'd0);
    chk("rst irm", irm, 32'd0);
    chk("rst br_target", br_target, 32'd0);
    chk("rst br_taken", {31'b0, br_taken}, 32'd0);
    chk("rst illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    rstn = 1'b1;
    step();

    foreach (tv[i]) begin
      drive(tv[i].op, tv[i].alusrc, tv[i].a, tv[i].b, tv[i].imm, tv[i].pc, tv[i].ir,
            tv[i].br_en, tv[i].jal);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk({tv[i].name, " valid"}, {31'b0, out_valid}, 32'd1);
      chk({tv[i].name, " y"}, y, tv[i].ey);
      chk({tv[i].name, " br_taken"}, {31'b0, br_taken}, {31'b0, tv[i].ebt});
      chk({tv[i].name, " illegal"}, {31'b0, illegal_op}, {31'b0, tv[i].eill});
      chk({tv[i].name, " br_target"}, br_target, tv[i].pc + tv[i].imm);
      chk({tv[i].name, " mdw"}, mdw, tv[i].b);
      chk({tv[i].name, " irm"}, irm, tv[i].ir);
      step();
      chk({tv[i].name, " valid clr"}, {31'b0, out_valid}, 32'd0);
    end

    // backpressure, with a competing op held on the input during the stall
    out_ready = 1'b0;
    drive(OP_ADD, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    drive(OP_SUB, 1'b0, 32'd9, 32'd1, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp y stable", y, 32'd7);
      chk("bp mdw stable", mdw, 32'd4);
      chk("bp valid held", {31'b0, out_valid}, 32'd1);
      chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp in_ready release", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b valid", {31'b0, out_valid}, 32'd1);
    chk("b2b y", y, 32'd8);
    step();
    chk("b2b drain", {31'b0, out_valid}, 32'd0);
    chk("b2b in_ready", {31'b0, in_ready}, 32'd1);

    // flush overrides a simultaneous accept
    drive(OP_ADD, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+accept dropped", {31'b0, out_valid}, 32'd0);
    step();
    chk("flush+accept later", {31'b0, out_valid}, 32'd0);

    // flush kills a held result
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("held before flush", {31'b0, out_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush kills held", {31'b0, out_valid}, 32'd0);
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);

    // async reset clears a held result immediately
    drive(OP_XOR, 1'b0, 32'h1, 32'h3, 32'h10, 32'h20, 32'h4033, 1'b0, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst valid", {31'b0, out_valid}, 32'd0);
    chk("arst y", y, 32'd0);
    chk("arst mdw", mdw, 32'd0);
    chk("arst irm", irm, 32'd0);
    chk("arst br_target", br_target, 32'd0);
    chk("arst br_taken", {31'b0, br_taken}, 32'd0);
    step();
    rstn = 1'b1;
    out_ready = 1'b1;
    chk("arst in_ready", {31'b0, in_ready}, 32'd1);
    step();

`ifdef EX_MULDIV_EN
    md_run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    md_run("divu by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
    md_run("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
    md_run("remu by0", OP_REMU, 32'd100, 32'd0, 32'd100);
    md_run("mul", OP_MUL, 32'd12345, 32'd6789, 32'd83810205);
    md_run("mul wrap", OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);

    // flush on the 10th cycle of a divide
    drive(OP_DIVU, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0200_5033, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("md flush valid", {31'b0, out_valid}, 32'd0);
    chk("md flush in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= out_valid;
    end
    chk("md flush no result", {31'b0, seen}, 32'd0);

    // reset pulse in the middle of a multiply
    drive(OP_MUL, 1'b0, 32'd5, 32'd6, 32'h4, 32'h8, 32'h0200_0033, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mul busy mdw", mdw, 32'd6);
    for (int i = 0; i < 5; i++) step();
    rstn = 1'b0;
    #1;
    chk("md arst valid", {31'b0, out_valid}, 32'd0);
    chk("md arst mdw", mdw, 32'd0);
    chk("md arst irm", irm, 32'd0);
    chk("md arst br_target", br_target, 32'd0);
    step();
    rstn = 1'b1;
    chk("md arst in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= out_valid;
    end
    chk("md arst no result", {31'b0, seen}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
